ram_16x4_master: RTL
====================

// Module: ram_16x4_master
// PURPOSE
//   Bus master for the 16x4 synchronous RAM (ram_16x4_sync). Accepts read, write and fill requests from
//   the 4-bit processor datapath over a valid/ready handshake. Drives the RAM's csn/rwn/addr/datain
//   pins and returns read data or write acks on a one-cycle response strobe.
//   Sits between the processor control unit and the data RAM; it is the initiator end of the RAM port.
// PARAMETERS
//   ADDR_W    4   RAM address width; fill walks 0 .. 2**ADDR_W-1
//   DATA_W    4   RAM data width
//   READ_LAT  1   cycles from RAM read edge to dataout valid; legal range >=1
// PORTS
//   clk          in   1       rising-edge clock, shared with the RAM
//   reset        in   1       asynchronous, active-high reset
//   req_valid    in   1       request present
//   req_ready    out  1       master idle, can accept; transfer when req_valid&&req_ready at posedge
//   req_op       in   2       00 read, 01 write, 10 fill all addresses, 11 reserved
//   req_addr     in   ADDR_W  target address (ignored for fill)
//   req_wdata    in   DATA_W  write data / fill value
//   resp_valid   out  1       one-cycle pulse: operation complete
//   resp_rdata   out  DATA_W  read data, valid with resp_valid for reads; holds last read otherwise
//   resp_err     out  1       with resp_valid: 1 = reserved op rejected
//   mem_csn      out  1       RAM chip select, active low
//   mem_rwn      out  1       RAM 1=read 0=write
//   mem_addr     out  ADDR_W  RAM address
//   mem_datain   out  DATA_W  RAM write data
//   mem_dataout  in   DATA_W  RAM read data
// BEHAVIOUR
//   - All outputs registered. Reset values: req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0,
//     mem_csn=1, mem_rwn=1, mem_addr=0, mem_datain=0, state=IDLE. req_ready=1 from first cycle after release.
//   - States: IDLE, WRITE, READ, RWAIT, FILL, RESP. req_ready=1 only in IDLE.
//   - Request accepted at posedge T. op latched; req_* may change afterwards.
//   - WRITE: in cycle T+1 drive csn=0, rwn=0, addr, datain. RAM commits at the end of T+1.
//     Cycle T+2: csn=1, rwn=1, resp_valid=1, req_ready=1.
//   - READ: in cycle T+1 drive csn=0, rwn=1, addr. RWAIT then counts READ_LAT cycles with csn=1.
//     mem_dataout is sampled at the end of cycle T+1+READ_LAT.
//     resp_valid and resp_rdata are presented in cycle T+2+READ_LAT (default 3 cycles after acceptance).
//   - FILL: cycles T+1..T+2**ADDR_W drive csn=0, rwn=0, datain=fill value, mem_addr=0,1,..,max,
//     ascending, one per cycle. 4-bit address counter; terminal count detected at max, no wrap past it.
//     csn=1 and resp_valid=1 in cycle T+2**ADDR_W+1 (T+17 by default).
//   - Reserved op 11: no RAM access, csn stays 1; resp_valid=1 with resp_err=1 in cycle T+1.
//   - resp_err=0 on all other responses.
//   - req_ready returns to 1 in the same cycle as resp_valid.
//     A new request may be accepted at the end of that cycle (back-to-back, no bubble beyond the response).
//   - req_valid while busy is ignored (not queued); requester must hold it until req_ready.
//   - Between accesses: mem_csn=1, mem_rwn=1. mem_addr/mem_datain hold last values.
//   - Reset asserted mid-operation: immediately csn=1, rwn=1, state IDLE. The in-flight operation is dropped
//     with no resp_valid. Fill may be partial; RAM contents are then undefined for unwritten addresses.
// TESTING
//   1 write op=01 addr=0100 data=1010, then read addr=0100 -> write ack at T+2; read resp at T+3,
//     resp_rdata=1010, resp_err=0
//   2 fill value=0101, then read addr 0000 and 1111 -> 16 consecutive csn=0 cycles, addr 0..15 ascending;
//     both reads return 0101; fill ack at T+17
//   3 req_valid held high with write 0011@0010 then read @0010 -> second request accepted in the ack
//     cycle; read returns 0011; req_ready low in all busy cycles
//   4 reserved op=11 -> resp_valid=1, resp_err=1 at T+1; mem_csn never low
//   5 reset pulse at fill cycle 6 -> csn=1 asynchronously, no resp_valid, req_ready=1 after release;
//     following read works normally
//   6 READ_LAT=2 build, read after write 1100@1001 -> resp at T+4 with resp_rdata=1100

Source files
------------

// File: rtl/ram_16x4_master.sv
// ram_16x4_master: valid/ready bus master driving a 16x4 synchronous RAM (read, write, fill, reserved-op reject)
//   clk, reset          rising-edge clock; asynchronous active-high reset
//   req_valid/req_ready request handshake, transfer on req_valid && req_ready at posedge
//   req_op              00 read, 01 write, 10 fill, 11 reserved (rejected with resp_err)
//   req_addr, req_wdata target address, write/fill data
//   resp_valid          one-cycle completion strobe; resp_rdata read data; resp_err reserved-op flag
//   mem_csn, mem_rwn    RAM chip select (active low), read/not-write
//   mem_addr, mem_datain, mem_dataout  RAM address, write data, read data
module ram_16x4_master #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 4,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_csn,
    output logic              mem_rwn,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout
);
    localparam int CW = READ_LAT > 1 ? $clog2(READ_LAT) : 1;
    typedef enum logic [2:0] {IDLE, WRITE, READ, RWAIT, FILL, RESP} state_t;
    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              ready_n, rv_n, err_n, csn_n, rwn_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] din_n, rd_n;
    // Every output is computed one cycle ahead here and registered below,
    // so the RAM pins and response strobe come straight from flops.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rv_n    = 1'b0;
        err_n   = 1'b0;
        csn_n   = 1'b1;
        rwn_n   = 1'b1;
        addr_n  = mem_addr;
        din_n   = mem_datain;
        rd_n    = resp_rdata;
        case (state)
            // RESP is the strobe cycle; it is also idle so a new request can follow with no bubble
            IDLE, RESP: begin
                state_n = IDLE;
                if (req_valid && req_ready) begin
                    case (req_op)
                        2'b00: begin
                            state_n = READ;
                            csn_n   = 1'b0;
                            addr_n  = req_addr;
                        end
                        2'b01: begin
                            state_n = WRITE;
                            csn_n   = 1'b0;
                            rwn_n   = 1'b0;
                            addr_n  = req_addr;
                            din_n   = req_wdata;
                        end
                        2'b10: begin
                            state_n = FILL;
                            csn_n   = 1'b0;
                            rwn_n   = 1'b0;
                            addr_n  = '0;
                            din_n   = req_wdata;
                        end
                        2'b11: begin
                            state_n = RESP;
                            rv_n    = 1'b1;
                            err_n   = 1'b1;
                        end
                    endcase
                end
            end
            WRITE: begin
                state_n = RESP;
                rv_n    = 1'b1;
            end
            READ: begin
                state_n = RWAIT;
                cnt_n   = '0;
            end
            RWAIT: begin
                if (cnt == CW'(READ_LAT - 1)) begin
                    state_n = RESP;
                    rv_n    = 1'b1;
                    rd_n    = mem_dataout;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            FILL: begin
                if (mem_addr == {ADDR_W{1'b1}}) begin
                    state_n = RESP;
                    rv_n    = 1'b1;
                end else begin
                    csn_n  = 1'b0;
                    rwn_n  = 1'b0;
                    addr_n = mem_addr + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == IDLE) || (state_n == RESP);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_csn    <= 1'b1;
            mem_rwn    <= 1'b1;
            mem_addr   <= '0;
            mem_datain <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            req_ready  <= ready_n;
            resp_valid <= rv_n;
            resp_err   <= err_n;
            resp_rdata <= rd_n;
            mem_csn    <= csn_n;
            mem_rwn    <= rwn_n;
            mem_addr   <= addr_n;
            mem_datain <= din_n;
        end
    end
endmodule
